// File: rtl/mem_access_wb_stage.sv
// Memory-stage data RAM access (address, byte enables, lane-shifted store data, AdEL/AdES)
// plus the MEM/WB register and the W-side load align/extend/merge that forms ResultW.
module mem_access_wb_stage #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              InterruptRequest,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic [1:0]        MemTypeM,
  input  logic              LoadExtSignM,
  input  logic              LeftRightM,
  input  logic              CP0ReadM,
  input  logic [ADDR_W-1:0] AddrM,
  input  logic [31:0]       WriteDataM,
  input  logic [31:0]       CP0RDataM,
  input  logic [4:0]        WriteRegM,
  output logic [ADDR_W-1:0] DMemAddr,
  output logic [3:0]        DMemWE,
  output logic [31:0]       DMemWData,
  input  logic [31:0]       DMemRData,
  output logic              AdELM,
  output logic              AdESM,
  output logic              RegWriteW,
  output logic [4:0]        WriteRegW,
  output logic [31:0]       ResultW
);

  logic [1:0] n;
  logic       misaligned;
  logic       kill;
  logic [4:0] lane_sh;   // 8*n
  logic [4:0] inv_sh;    // 8*(3-n); 3-n == ~n for two bits
  logic [4:0] swl_mask;
  logic [3:0] we_lanes;

  assign n          = AddrM[1:0];
  assign lane_sh    = {n, 3'b000};
  assign inv_sh     = {~n, 3'b000};
  assign misaligned = ((MemTypeM == 2'd0) && (n != 2'd0)) || ((MemTypeM == 2'd1) && n[0]);
  assign AdELM      = MemtoRegM && misaligned;
  assign AdESM      = MemWriteM && misaligned;
  assign kill       = reset || InterruptRequest || AdELM || AdESM;
  assign DMemAddr   = {AddrM[ADDR_W-1:2], 2'b00};
  assign swl_mask   = (5'd2 << n) - 5'd1;

  always_comb begin
    we_lanes  = 4'b0000;
    DMemWData = WriteDataM;
    case (MemTypeM)
      2'd0: begin
        we_lanes  = 4'b1111;
        DMemWData = WriteDataM;
      end
      2'd1: begin
        we_lanes  = n[1] ? 4'b1100 : 4'b0011;
        DMemWData = {WriteDataM[15:0], WriteDataM[15:0]};
      end
      2'd2: begin
        we_lanes  = 4'b0001 << n;
        DMemWData = {4{WriteDataM[7:0]}};
      end
      default: begin
        if (LeftRightM) begin
          we_lanes  = swl_mask[3:0];
          DMemWData = WriteDataM >> inv_sh;
        end else begin
          we_lanes  = 4'b1111 << n;
          DMemWData = WriteDataM << lane_sh;
        end
      end
    endcase
  end

  assign DMemWE = (MemWriteM && !kill) ? we_lanes : 4'b0000;

  logic              reg_write_q;
  logic [4:0]        write_reg_q;
  logic              mem_to_reg_q;
  logic [1:0]        mem_type_q;
  logic              ext_sign_q;
  logic              left_right_q;
  logic              cp0_read_q;
  logic [1:0]        n_q;
  logic [ADDR_W-1:0] alu_out_q;
  logic [31:0]       cp0_rdata_q;
  logic [31:0]       rt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      mem_to_reg_q <= 1'b0;
      mem_type_q   <= 2'd0;
      ext_sign_q   <= 1'b0;
      left_right_q <= 1'b0;
      cp0_read_q   <= 1'b0;
      n_q          <= 2'd0;
      alu_out_q    <= '0;
      cp0_rdata_q  <= 32'd0;
      rt_q         <= 32'd0;
    end else if (kill) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      cp0_read_q   <= 1'b0;
    end else begin
      reg_write_q  <= RegWriteM;
      write_reg_q  <= WriteRegM;
      mem_to_reg_q <= MemtoRegM;
      mem_type_q   <= MemTypeM;
      ext_sign_q   <= LoadExtSignM;
      left_right_q <= LeftRightM;
      cp0_read_q   <= CP0ReadM;
      n_q          <= n;
      alu_out_q    <= AddrM;
      cp0_rdata_q  <= CP0RDataM;
      rt_q         <= WriteDataM;
    end
  end

  logic [4:0]  lane_sh_w;
  logic [4:0]  inv_sh_w;
  logic [15:0] half_w;
  logic [31:0] byte_word_w;
  logic [31:0] load_val;

  assign lane_sh_w   = {n_q, 3'b000};
  assign inv_sh_w    = {~n_q, 3'b000};
  assign half_w      = n_q[1] ? DMemRData[31:16] : DMemRData[15:0];
  assign byte_word_w = DMemRData >> lane_sh_w;

  always_comb begin
    load_val = DMemRData;
    case (mem_type_q)
      2'd0: load_val = DMemRData;
      2'd1: load_val = {{16{ext_sign_q & half_w[15]}}, half_w};
      2'd2: load_val = {{24{ext_sign_q & byte_word_w[7]}}, byte_word_w[7:0]};
      default: begin
        // Unaligned loads merge the RAM bytes into the old rt value.
        if (left_ray_sel(left_right_q)) begin
          load_val = (DMemRData << inv_sh_w) | (rt_q & ((32'd1 << inv_sh_w) - 32'd1));
        end else begin
          load_val = (DMemRData >> lane_sh_w) | (rt_q & ~(32'hFFFF_FFFF >> lane_sh_w));
        end
      end
    endcase
  end

  function automatic logic left_ray_sel(input logic lr);
    return lr;
  endfunction

  assign RegWriteW = reg_write_q;
  assign WriteRegW = write_reg_q;
  assign ResultW   = mem_to_reg_q ? load_val :
                     cp0_read_q   ? cp0_rdata_q : 32'(alu_out_q);

endmodule

// File: doc/mem_access_wb_stage.md
Name: mem_access_wb_stage

Overview:
- Memory-stage data-memory access unit plus MEM/WB pipeline register.
- Consumes the M-stage control bundle (RegWriteM, MemtoRegM, MemWriteM, MemTypeM, LoadExtSignM, LeftRightM, CP0ReadM) and the M-stage datapath values.
- Drives the synchronous data RAM with a word-aligned address, byte enables and lane-shifted store data, and flags address-error exceptions.
- Registers the result into WB, then aligns, extends and merges the RAM read data that returns one cycle later to form the register-file write value.

Parameters:
- ADDR_W, 32, byte-address width of AddrM/DMemAddr.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- InterruptRequest  in  1  flush M instruction: no store, no WB write.
- RegWriteM  in  1  M instruction writes GPR.
- MemtoRegM  in  1  M instruction is a load.
- MemWriteM  in  1  M instruction is a store.
- MemTypeM  in  2  0=word, 1=half, 2=byte, 3=unaligned (LWL/LWR/SWL/SWR).
- LoadExtSignM  in  1  1=sign-extend LB/LH, 0=zero-extend.
- LeftRightM  in  1  for MemTypeM=3: 1=left (LWL/SWL), 0=right (LWR/SWR).
- CP0ReadM  in  1  result comes from CP0 (MFC0).
- AddrM  in  ADDR_W  effective byte address / ALU result.
- WriteDataM  in  32  store data (rt).
- CP0RDataM  in  32  CP0 read value.
- WriteRegM  in  5  destination GPR.
- DMemAddr  out  ADDR_W  {AddrM[ADDR_W-1:2],2'b00}, combinational.
- DMemWE  out  4  byte write enables, bit k = byte lane k (little-endian), combinational.
- DMemWData  out  32  lane-shifted store data, combinational.
- DMemRData  in  32  RAM word for address presented in the previous cycle.
- AdELM  out  1  misaligned load, combinational.
- AdESM  out  1  misaligned store, combinational.
- RegWriteW  out  1  registered.
- WriteRegW  out  5  registered.
- ResultW  out  32  WB value; combinational from W registers and DMemRData.

Behaviour:
- n = AddrM[1:0] in M; nW = registered copy in W.
- Alignment rules:
  - AdELM = MemtoRegM & ((MemTypeM==0 & n!=0) | (MemTypeM==1 & n[0])).
  - AdESM: same expression with MemWriteM in place of MemtoRegM.
  - MemTypeM 2 and 3 never fault.
- Kill = reset | InterruptRequest | AdELM | AdESM. When Kill is high, DMemWE=0.
- Store lanes (when MemWriteM & !Kill):
  - SW: WE=1111, data=rt.
  - SH: WE=0011 (n=0) or 1100 (n=2); data={rt[15:0],rt[15:0]}.
  - SB: WE=1<<n; data=rt[7:0] replicated four times.
  - SWL: WE=(2<<n)-1; data=rt>>(8*(3-n)).
  - SWR: WE=4'b1111<<n; data=rt<<(8*n).
- WB register (posedge clk):
  - If Kill: RegWriteW=0, MemtoRegW=0, CP0ReadW=0; other W fields don't-care but reset to 0 on reset.
  - Else capture RegWriteM, WriteRegM, MemtoRegM, MemTypeM, LoadExtSignM, LeftRightM, CP0ReadM, n, AddrM (as ALUOutW), CP0RDataM, and WriteDataM (as RtW, old rt for LWL/LWR merge).
- Reset values: RegWriteW=0, WriteRegW=0, all internal W registers 0, hence ResultW=0.
- Load alignment in W (m = DMemRData):
  - LW: m.
  - LH: half = nW[1] ? m[31:16] : m[15:0]; sign- or zero-extended per LoadExtSignW.
  - LB: byte nW, extended likewise.
  - LWL: (m << 8*(3-nW)) | (RtW & ((1<<8*(3-nW))-1)).
  - LWR: (m >> 8*nW) | (RtW & ~(32'hFFFFFFFF >> 8*nW)).
- ResultW = MemtoRegW ? aligned load : CP0ReadW ? CP0RDataW : ALUOutW.
- Latency: store commits at the posedge ending the M cycle; load data is valid in the W cycle (1-cycle RAM). No stall input; the stage advances every cycle.
- Simultaneous InterruptRequest and store: store suppressed. A fault and an interrupt in the same cycle: both suppress; AdEL/AdES still reported.
- Reset mid-load: W cleared; the RAM word arriving next cycle is ignored (RegWriteW=0).

Test Plan:
- SB, AddrM=0x00000103, rt=0xAABBCCDD -> DMemAddr=0x00000100, DMemWE=1000, DMemWData=0xDDDDDDDD; next cycle RegWriteW=0 if RegWriteM=0.
- LH sign, AddrM=0x00000012, DMemRData=0x8001_7FFF in W -> ResultW=0xFFFF8001. Repeat with LoadExtSignM=0 -> 0x00008001.
- LWL, nW=1, RtW=0x11223344, m=0xAABBCCDD -> ResultW=0xCCDD3344. LWR, nW=1, same inputs -> 0x11AABBCC.
- LW at AddrM=0x00000006 -> AdELM=1, DMemWE=0; next cycle RegWriteW=0. SH at 0x00000005 -> AdESM=1, DMemWE=0000.
- SW with InterruptRequest=1 -> DMemWE=0000 and RegWriteW=0 next cycle. Same instruction without interrupt -> DMemWE=1111.
- Reset held during a load cycle -> RegWriteW=0, WriteRegW=0, ResultW=0 after the edge. ALU op with CP0ReadM=1, CP0RDataM=0xDEADBEEF -> ResultW=0xDEADBEEF, RegWriteW=1.
